// File: rtl/cmd_bus_arbiter.sv
// Round-robin arbiter that shares one command bus among NUM_REQ sources: hold window, then zero gap.
// Build option: define CMD_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
//
// state | meaning
// IDLE  | bus at zero, picks the next valid requester
// DRIVE | granted word and Cmd_En_Out held for max(HOLD_CYC,1) cycles
// GAP   | bus forced to zero for GAP_CYC cycles
module cmd_bus_arbiter #(
   parameter int         NUM_REQ   = 4,
   parameter int         CMD_WIDTH = 16,
   parameter logic [7:0] HOLD_CYC  = 8'd4,
   parameter logic [7:0] GAP_CYC   = 8'd2
) (
   input  logic                         Clk_In,
   input  logic                         Rst_N,
   input  logic [NUM_REQ*CMD_WIDTH-1:0] Req_Cmd_In,
   input  logic [NUM_REQ-1:0]           Req_Valid,
   output logic [NUM_REQ-1:0]           Req_Ack,
   output logic [CMD_WIDTH-1:0]         Cmd_Out,
   output logic                         Cmd_En_Out,
   output logic [2:0]                   Grant_Id,
   output logic                         Busy
);

   localparam int         IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [7:0] HOLD_EFF = (HOLD_CYC == 8'd0) ? 8'd1 : HOLD_CYC;

   typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

   state_t                 state_q, state_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [CMD_WIDTH-1:0]   cmd_d;
   logic                   en_d;
   logic [NUM_REQ-1:0]     ack_d;
   logic [2:0]             gid_d;
   logic                   found;
   logic [IW-1:0]          sel, cand;
   logic [CMD_WIDTH-1:0]   req_word [NUM_REQ];
`ifndef CMD_ARB_FIXED_PRIO_EN
   logic [IW-1:0]          ptr_q, ptr_d;
`endif

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_word[i] = Req_Cmd_In[i*CMD_WIDTH +: CMD_WIDTH];
      end
   end

   // Search starts just after the last grant (zero-based pointer) and wraps.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CMD_ARB_FIXED_PRIO_EN
         cand = IW'(k);
`else
         cand = IW'((int'(ptr_q) + 1 + k) % NUM_REQ);
`endif
         if (!found && Req_Valid[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = Cmd_Out;
      en_d    = Cmd_En_Out;
      ack_d   = '0;
      gid_d   = Grant_Id;
`ifndef CMD_ARB_FIXED_PRIO_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               ack_d[sel] = 1'b1;
               gid_d      = 3'(sel) + 3'd1;
`ifndef CMD_ARB_FIXED_PRIO_EN
               ptr_d      = sel;
`endif
               // A zero word is the idle value: acked and consumed without driving the bus.
               if (req_word[sel] != '0) begin
                  cmd_d   = req_word[sel];
                  en_d    = 1'b1;
                  cnt_d   = HOLD_EFF;
                  state_d = DRIVE;
               end
            end
         end
         DRIVE: begin
            if (cnt_q == 8'd1) begin
               cmd_d = '0;
               en_d  = 1'b0;
               if (GAP_CYC == 8'd0) begin
                  state_d = IDLE;
               end else begin
                  state_d = GAP;
                  cnt_d   = GAP_CYC;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         GAP: begin
            if (cnt_q == 8'd1) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk_In or negedge Rst_N) begin
      if (!Rst_N) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         Cmd_Out    <= '0;
         Cmd_En_Out <= 1'b0;
         Req_Ack    <= '0;
         Grant_Id   <= 3'd0;
`ifndef CMD_ARB_FIXED_PRIO_EN
         ptr_q      <= IW'(NUM_REQ - 1);
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         Cmd_Out    <= cmd_d;
         Cmd_En_Out <= en_d;
         Req_Ack    <= ack_d;
         Grant_Id   <= gid_d;
`ifndef CMD_ARB_FIXED_PRIO_EN
         ptr_q      <= ptr_d;
`endif
      end
   end

   assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// Directed bench for cmd_bus_arbiter (NUM_REQ=4, HOLD=4, GAP=2); covers CMD_ARB_FIXED_PRIO_EN too.
module tb_cmd_bus_arbiter;

   localparam int NUM_REQ = 4;
   localparam int W       = 16;

   logic                 clk       = 1'b0;
   logic                 rst_n     = 1'b0;
   logic [NUM_REQ*W-1:0] req_cmd   = '0;
   logic [NUM_REQ-1:0]   req_valid = '0;
   logic [NUM_REQ-1:0]   req_ack;
   logic [W-1:0]         cmd_out;
   logic                 cmd_en;
   logic [2:0]           grant_id;
   logic                 busy;

   int checks   = 0;
   int failures = 0;
   int multi    = 0;

   always #5 clk = ~clk;

   cmd_bus_arbiter #(
      .NUM_REQ(NUM_REQ), .CMD_WIDTH(W), .HOLD_CYC(8'd4), .GAP_CYC(8'd2)
   ) dut (
      .Clk_In(clk), .Rst_N(rst_n), .Req_Cmd_In(req_cmd), .Req_Valid(req_valid),
      .Req_Ack(req_ack), .Cmd_Out(cmd_out), .Cmd_En_Out(cmd_en),
      .Grant_Id(grant_id), .Busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_word(input int i, input logic [W-1:0] w);
      req_cmd[(i-1)*W +: W] = w;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_ack(input int budget, output logic [NUM_REQ-1:0] a,
                           output logic [W-1:0] w, output int idle_run);
      a = '0; w = '0; idle_run = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if ($countones(req_ack) > 1) multi++;
         if (req_ack != '0) begin
            a = req_ack;
            w = cmd_out;
            return;
         end
         if (!cmd_en) idle_run++;
         else idle_run = 0;
      end
   endtask

   task automatic wait_idle(input int budget);
      int c;
      c = 0;
      while (busy && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NUM_REQ-1:0] a;
      logic [W-1:0]       w;
      int                 run;
      logic [W-1:0]       words [4];
      words[0] = 16'h0011; words[1] = 16'h0022; words[2] = 16'h0033; words[3] = 16'h0044;

      // reset values
      @(negedge clk);
      @(negedge clk);
      chk("rst_cmd",  cmd_out, 0);
      chk("rst_en",   cmd_en, 0);
      chk("rst_ack",  req_ack, 0);
      chk("rst_gid",  grant_id, 0);
      chk("rst_busy", busy, 0);

      // single request: 4 drive cycles, 2 gap cycles
      rst_n = 1'b1;
      set_word(1, 16'h55aa);
      req_valid = 4'b0001;
      @(negedge clk);
      chk("t1_ack",  req_ack, 4'b0001);
      chk("t1_cmd",  cmd_out, 16'h55aa);
      chk("t1_en",   cmd_en, 1);
      chk("t1_busy", busy, 1);
      chk("t1_gid",  grant_id, 1);
      req_valid = '0;
      for (int c = 1; c < 4; c++) begin
         @(negedge clk);
         chk("t1_hold_cmd", cmd_out, 16'h55aa);
         chk("t1_hold_en",  cmd_en, 1);
         chk("t1_hold_ack", req_ack, 0);
      end
      @(negedge clk);
      chk("t1_gap_cmd",  cmd_out, 0);
      chk("t1_gap_en",   cmd_en, 0);
      chk("t1_gap_busy", busy, 1);
      @(negedge clk);
      chk("t1_gap2_busy", busy, 1);
      @(negedge clk);
      chk("t1_idle_busy", busy, 0);

      // requester 3 raises valid during DRIVE of requester 1
      set_word(1, 16'h1111);
      req_valid = 4'b0001;
      @(negedge clk);
      chk("t3_ack1", req_ack, 4'b0001);
      req_valid = '0;
      @(negedge clk);
      set_word(3, 16'h3333);
      req_valid = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t3_no_ack", req_ack, 0);
      end
      chk("t3_idle", busy, 0);
      @(negedge clk);
      chk("t3_ack3", req_ack, 4'b0100);
      chk("t3_cmd",  cmd_out, 16'h3333);
      chk("t3_gid",  grant_id, 3);
      req_valid = '0;
      @(negedge clk);
      wait_idle(20);

      // zero word from requester 2
      set_word(2, 16'h0000);
      req_valid = 4'b0010;
      @(negedge clk);
      chk("t4_ack",  req_ack, 4'b0010);
      chk("t4_gid",  grant_id, 2);
      chk("t4_en",   cmd_en, 0);
      chk("t4_busy", busy, 0);
      chk("t4_cmd",  cmd_out, 0);
      req_valid = '0;
      @(negedge clk);
      chk("t4_ack_pulse", req_ack, 0);
      chk("t4_busy2", busy, 0);

      // reset during the 2nd DRIVE cycle; pointer must return to favour requester 1
      set_word(2, 16'h2222);
      req_valid = 4'b0010;
      @(negedge clk);
      chk("t5_ack2", req_ack, 4'b0010);
      req_valid = '0;
      @(negedge clk);
      chk("t5_drive", cmd_out, 16'h2222);
      rst_n = 1'b0;
      #1;
      chk("t5_async_cmd",  cmd_out, 0);
      chk("t5_async_en",   cmd_en, 0);
      chk("t5_async_busy", busy, 0);
      chk("t5_async_gid",  grant_id, 0);
      @(negedge clk);
      rst_n = 1'b1;
      set_word(1, 16'h0101);
      set_word(3, 16'h0303);
      req_valid = 4'b0101;
      @(negedge clk);
      chk("t5_ptr_ack", req_ack, 4'b0001);
      chk("t5_ptr_cmd", cmd_out, 16'h0101);
      chk("t5_ptr_gid", grant_id, 1);
      req_valid = '0;

      // all four continuously valid
      do_reset();
      for (int i = 0; i < 4; i++) set_word(i + 1, words[i]);
      req_valid = 4'b1111;
      multi = 0;
      for (int k = 0; k < 5; k++) begin
         wait_ack(30, a, w, run);
`ifdef CMD_ARB_FIXED_PRIO_EN
         chk("t6_ack",  a, 4'b0001);
         chk("t6_word", w, words[0]);
`else
         chk("t6_ack",  a, 4'b0001 << (k % 4));
         chk("t6_word", w, words[k % 4]);
`endif
         if (k > 0) chk("t6_gap_ge3", (run >= 3) ? 1 : 0, 1);
      end
      req_valid = '0;
      chk("t6_onehot", multi, 0);

      // requesters 2 and 4 continuously valid
      do_reset();
      set_word(2, 16'h0222);
      set_word(4, 16'h0444);
      req_valid = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         wait_ack(30, a, w, run);
`ifdef CMD_ARB_FIXED_PRIO_EN
         chk("t7_ack", a, 4'b0010);
         chk("t7_gid", grant_id, 2);
`else
         chk("t7_ack", a, (k % 2 == 0) ? 4'b0010 : 4'b1000);
         chk("t7_gid", grant_id, (k % 2 == 0) ? 2 : 4);
`endif
      end
      req_valid = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
